irq_controller: RTL and testbench

//   Wishbone-slave interrupt controller: collects NUM_SRC external/peripheral IRQ lines,

---
 rtl/irq_controller.sv | 157 +++++++++++++++
 tb/tb_irq_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Wishbone interrupt controller: synchronised sources latch into PENDING, fixed-priority claim/complete, single CPU IRQ.
// Optional build macro IRQC_EDGE_DETECT_EN selects rising-edge capture instead of level capture.
module irq_controller #(
  parameter int NUM_SRC     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [3:0]         wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  input  logic [NUM_SRC-1:0] irq_src_i,
  output logic               irq_o
);

  localparam logic [1:0] ADR_PENDING = 2'd0;
  localparam logic [1:0] ADR_ENABLE  = 2'd1;
  localparam logic [1:0] ADR_CLAIM   = 2'd2;
  localparam logic [1:0] ADR_STATUS  = 2'd3;

  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] set_q, set_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] synced_s;
  logic [4:0]         insvc_q, insvc_d;
  logic [4:0]         claim_id_s;
  logic               ack_q, ack_d;
  logic               irq_q, irq_d;
  logic               req_s;
  logic [31:0]        dat_q, dat_d;
`ifdef IRQC_EDGE_DETECT_EN
  logic [NUM_SRC-1:0] prev_q, prev_d;
`endif

  // Lowest set index wins; returns index+1, or 0 when nothing is set.
  function automatic logic [4:0] first_id(input logic [NUM_SRC-1:0] v);
    logic [4:0] id;
    id = 5'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) id = 5'(i + 1);
      else      id = id;
    end
    return id;
  endfunction

  function automatic logic [NUM_SRC-1:0] id_mask(input logic [4:0] id);
    logic [NUM_SRC-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id == 5'(i + 1)) m[i] = 1'b1;
      else                 m[i] = 1'b0;
    end
    return m;
  endfunction

  // Next-state logic for the synchroniser, bus decode, pending/in-service and IRQ output.
  always_comb begin
    req_s      = wb_cyc_i & wb_stb_i & ~ack_q;
    synced_s   = sync_q[SYNC_STAGES-1];
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_src_i};
    claim_id_s = (insvc_q == 5'd0) ? first_id(pending_q & enable_q) : 5'd0;
    ack_d      = req_s;
    dat_d      = 32'd0;
    enable_d   = enable_q;
    insvc_d    = insvc_q;
    clr_s      = '0;
`ifdef IRQC_EDGE_DETECT_EN
    prev_d     = synced_s;
    set_d      = synced_s & ~prev_q;
`else
    set_d      = synced_s;
`endif

    if (req_s) begin
      case (wb_adr_i[3:2])
        ADR_PENDING: begin
          if (!wb_we_i) dat_d = {{(32-NUM_SRC){1'b0}}, pending_q};
          else          dat_d = 32'd0;
        end
        ADR_ENABLE: begin
          if (wb_we_i) enable_d = wb_dat_i[NUM_SRC-1:0];
          else         dat_d    = {{(32-NUM_SRC){1'b0}}, enable_q};
        end
        ADR_CLAIM: begin
          if (wb_we_i) begin
            if (wb_dat_i[4:0] == insvc_q) insvc_d = 5'd0;
            else                          insvc_d = insvc_q;
          end else begin
            dat_d = {27'd0, claim_id_s};
            if (claim_id_s != 5'd0) begin
              insvc_d = claim_id_s;
              clr_s   = id_mask(claim_id_s);
            end else begin
              insvc_d = insvc_q;
            end
          end
        end
        ADR_STATUS: begin
          if (!wb_we_i) dat_d = {19'd0, insvc_q, 7'd0, irq_q};
          else          dat_d = 32'd0;
        end
        default: dat_d = 32'd0;
      endcase
    end else begin
      dat_d = 32'd0;
    end

`ifdef IRQC_EDGE_DETECT_EN
    // A fresh edge beats a same-cycle claim so it is never lost.
    pending_d = (pending_q & ~clr_s) | set_q;
`else
    pending_d = (pending_q | (set_q & ~id_mask(insvc_q))) & ~clr_s;
`endif

    irq_d = (|(pending_q & enable_q)) && (insvc_q == 5'd0);
  end

  // State registers; an asserted reset also drops any bus cycle in flight.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q    <= '0;
      set_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      insvc_q   <= 5'd0;
      ack_q     <= 1'b0;
      dat_q     <= 32'd0;
      irq_q     <= 1'b0;
`ifdef IRQC_EDGE_DETECT_EN
      prev_q    <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      set_q     <= set_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      insvc_q   <= insvc_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      irq_q     <= irq_d;
`ifdef IRQC_EDGE_DETECT_EN
      prev_q    <= prev_d;
`endif
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed and randomised bench for irq_controller against a pending/enable/in-service model.
module tb_irq_controller;
  logic        clk = 1'b0;
  logic        reset_i;
  logic        cyc, stb, we;
  logic [3:0]  adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic [7:0]  src;
  logic        irq;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  m_pend;
  logic [7:0]  m_en;
  logic [31:0] rdata;
  logic [31:0] exp_v;
  logic [4:0]  exp_id;

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(8), .SYNC_STAGES(2)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .irq_src_i(src), .irq_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] wd, output logic [31:0] rd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = wd;
    @(posedge clk); #1;
    check("ack", {31'd0, ack}, 32'd1);
    rd = dat_o;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    bus(1'b0, a, 32'd0, d);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused;
    bus(1'b1, a, d, unused);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] m, input int hi, input int lo);
    @(negedge clk);
    src = src | m;
    repeat (hi) @(negedge clk);
    src = src & ~m;
    repeat (lo) @(negedge clk);
  endtask

  // Highest-priority enabled pending source as index+1.
  function automatic logic [4:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 5'(i + 1);
    return 5'd0;
  endfunction

  initial begin
    reset_i = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = 4'd0; dat_i = 32'd0; src = 8'd0;
    idle(3);
    reset_i = 1'b1;
    idle(2);

    // Reset dropped in the middle of an ENABLE write.
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 4'h4; dat_i = 32'hFF;
    #2 reset_i = 1'b0;
    @(posedge clk); #1;
    check("reset_no_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    rd_reg(4'h0, rdata); check("rst_pending", rdata, 32'd0);
    rd_reg(4'h4, rdata); check("rst_enable", rdata, 32'd0);
    rd_reg(4'h8, rdata); check("rst_claim", rdata, 32'd0);
    rd_reg(4'hC, rdata); check("rst_status", rdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);

    // Source-to-irq latency and basic claim/complete.
    wr_reg(4'h4, 32'h04);
    @(negedge clk);
    src[2] = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("lat_edge3", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("lat_edge4", {31'd0, irq}, 32'd1);
    @(negedge clk);
    src[2] = 1'b0;
    idle(4);
    rd_reg(4'h8, rdata); check("t2_claim", rdata, 32'h3);
    @(posedge clk); #1;
    check("t2_irq_drop", {31'd0, irq}, 32'd0);
    rd_reg(4'hC, rdata); check("t2_status", rdata, 32'h300);
    wr_reg(4'h8, 32'h3);
    rd_reg(4'hC, rdata); check("t2_status_done", rdata, 32'h0);

    // Simultaneous arrivals, no nesting.
    wr_reg(4'h4, 32'hFF);
    pulse(8'h12, 3, 5);
    rd_reg(4'h8, rdata); check("t3_claim1", rdata, 32'h2);
    rd_reg(4'h8, rdata); check("t3_busy", rdata, 32'h0);
    wr_reg(4'h8, 32'h2);
    rd_reg(4'h8, rdata); check("t3_claim4", rdata, 32'h5);
    wr_reg(4'h8, 32'h5);
    rd_reg(4'h8, rdata); check("t3_empty", rdata, 32'h0);

    // Disabled source still latches; enabling raises irq next cycle.
    wr_reg(4'h4, 32'h00);
    pulse(8'h08, 3, 5);
    rd_reg(4'h0, rdata); check("t4_pending", rdata, 32'h08);
    check("t4_irq_masked", {31'd0, irq}, 32'd0);
    wr_reg(4'h4, 32'h08);
    @(posedge clk); #1;
    check("t4_irq_enabled", {31'd0, irq}, 32'd1);
    rd_reg(4'h8, rdata); check("t4_claim", rdata, 32'h4);
    wr_reg(4'h8, 32'h4);

    // Held source: level re-arms after complete, edge does not.
    wr_reg(4'h4, 32'h01);
    @(negedge clk);
    src[0] = 1'b1;
    idle(6);
    rd_reg(4'h8, rdata); check("t5_claim", rdata, 32'h1);
    wr_reg(4'h8, 32'h1);
    idle(3);
`ifdef IRQC_EDGE_DETECT_EN
    exp_v = 32'h0;
`else
    exp_v = 32'h1;
`endif
    rd_reg(4'h0, rdata); check("t5_pending", rdata, exp_v);
    check("t5_irq", {31'd0, irq}, exp_v);
    @(negedge clk);
    src[0] = 1'b0;
    idle(6);
    rd_reg(4'h8, rdata); check("t5_cleanup", rdata, exp_v);
    wr_reg(4'h8, 32'h1);

    // Pulses of a source while it is in service.
    wr_reg(4'h4, 32'h20);
    pulse(8'h20, 3, 5);
    rd_reg(4'h8, rdata); check("t6_claim", rdata, 32'h6);
    pulse(8'h20, 2, 4);
    pulse(8'h20, 2, 5);
    rd_reg(4'h8, rdata); check("t6_busy", rdata, 32'h0);
    wr_reg(4'h8, 32'h6);
`ifdef IRQC_EDGE_DETECT_EN
    exp_v = 32'h6;
`else
    exp_v = 32'h0;
`endif
    rd_reg(4'h8, rdata); check("t6_after", rdata, exp_v);
    wr_reg(4'h8, 32'h6);
    rd_reg(4'h8, rdata); check("t6_once", rdata, 32'h0);

    // PENDING is read-only.
    pulse(8'h81, 3, 5);
    wr_reg(4'h0, 32'h0);
    rd_reg(4'h0, rdata); check("pend_ro", rdata, 32'h81);
    m_pend = 8'h81;

    // Randomised rounds against the pending/enable model.
    for (int it = 0; it < 20; it++) begin
      m_en = 8'($urandom);
      wr_reg(4'h4, {24'd0, m_en});
      begin
        logic [7:0] pat;
        pat = 8'($urandom);
        pulse(pat, 3, 5);
        m_pend = m_pend | pat;
      end
      rd_reg(4'h0, rdata); check("rnd_pending", rdata, {24'd0, m_pend});
      rd_reg(4'h4, rdata); check("rnd_enable", rdata, {24'd0, m_en});
      check("rnd_irq", {31'd0, irq}, {31'd0, (m_pend & m_en) != 8'd0});
      for (int c = 0; c < int'($urandom_range(1, 3)); c++) begin
        exp_id = lowest(m_pend & m_en);
        rd_reg(4'h8, rdata); check("rnd_claim", rdata, {27'd0, exp_id});
        if (exp_id != 5'd0) begin
          m_pend[exp_id - 5'd1] = 1'b0;
          rd_reg(4'hC, rdata); check("rnd_status", rdata, {19'd0, exp_id, 8'd0});
          wr_reg(4'h8, {27'd0, exp_id});
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
